// File: rtl/sm83_bus_if.sv
// sm83_bus_if: SM83 external bus interface. Turns core read/write requests
// sampled on the t4 edge into a registered four-T-state external bus cycle.
// Optional build macro SM83_BUS_STATS_EN adds saturating rd_count/wr_count
// statistics outputs; without it those ports do not exist.
module sm83_bus_if (
  input  logic        clk,
  input  logic        reset,
  input  logic        t1,
  input  logic        t2,
  input  logic        t3,
  input  logic        t4,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_dout,
  input  logic [7:0]  ext_din,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_dout,
  output logic        ext_drv,
  output logic        ext_rd_n,
  output logic        ext_wr_n,
  output logic [7:0]  din,
  output logic        din_valid,
  output logic        busy,
`ifdef SM83_BUS_STATS_EN
  output logic [15:0] rd_count,
  output logic [15:0] wr_count,
`endif
  output logic        proto_err
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2
  } state_t;

  // True when exactly one T-strobe is asserted.
  function automatic logic strobe_onehot(input logic [3:0] s);
    return (s != 4'd0) && ((s & (s - 4'd1)) == 4'd0);
  endfunction

  state_t      state_r;
  state_t      state_nx_s;
  logic [3:0]  strobe_s;
  logic        strobe_ok_s;
  logic        edge4_s;
  logic        rd_start_s;
  logic        wr_start_s;

  logic [15:0] ext_addr_nx_s;
  logic [7:0]  ext_dout_nx_s;
  logic        ext_drv_nx_s;
  logic        ext_rd_n_nx_s;
  logic        ext_wr_n_nx_s;
  logic [7:0]  din_nx_s;
  logic        din_valid_nx_s;
  logic        busy_nx_s;
  logic        proto_err_nx_s;

  assign strobe_s    = {t4, t3, t2, t1};
  assign strobe_ok_s = strobe_onehot(strobe_s);
  assign edge4_s     = strobe_ok_s & t4;
  // A simultaneous read and write request resolves to the read.
  assign rd_start_s  = edge4_s & req_rd;
  assign wr_start_s  = edge4_s & req_wr & ~req_rd;

  // State register; bad strobes leave the state untouched via state_nx_s.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next state: decisions only on a clean t4 edge, otherwise hold.
  always_comb begin
    state_nx_s = state_r;
    if (rd_start_s) begin
      state_nx_s = ST_RD;
    end else if (wr_start_s) begin
      state_nx_s = ST_WR;
    end else if (edge4_s) begin
      state_nx_s = ST_IDLE;
    end else begin
      state_nx_s = state_r;
    end
  end

  // Next output values: bus cycle starts on t4, write strobe opens on t1,
  // read data is captured and strobes close on t3.
  always_comb begin
    ext_addr_nx_s  = ext_addr;
    ext_dout_nx_s  = ext_dout;
    ext_drv_nx_s   = ext_drv;
    ext_rd_n_nx_s  = ext_rd_n;
    ext_wr_n_nx_s  = ext_wr_n;
    din_nx_s       = din;
    din_valid_nx_s = 1'b0;
    busy_nx_s      = busy;
    proto_err_nx_s = proto_err | ~strobe_ok_s | (edge4_s & req_rd & req_wr);
    if (edge4_s) begin
      busy_nx_s     = rd_start_s | wr_start_s;
      ext_rd_n_nx_s = ~rd_start_s;
      ext_wr_n_nx_s = 1'b1;
      ext_drv_nx_s  = wr_start_s;
      if (rd_start_s || wr_start_s) begin
        ext_addr_nx_s = req_addr;
      end else begin
        ext_addr_nx_s = ext_addr;
      end
      if (wr_start_s) begin
        ext_dout_nx_s = req_dout;
      end else begin
        ext_dout_nx_s = ext_dout;
      end
    end else if (strobe_ok_s && t1 && (state_r == ST_WR)) begin
      ext_wr_n_nx_s = 1'b0;
    end else if (strobe_ok_s && t3) begin
      case (state_r)
        ST_RD: begin
          ext_rd_n_nx_s  = 1'b1;
          din_nx_s       = ext_din;
          din_valid_nx_s = 1'b1;
        end
        ST_WR: begin
          ext_wr_n_nx_s = 1'b1;
        end
        default: begin
          ext_rd_n_nx_s = ext_rd_n;
        end
      endcase
    end else begin
      busy_nx_s = busy;
    end
  end

  // Output registers; reset drops every strobe immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_addr  <= 16'h0000;
      ext_dout  <= 8'h00;
      ext_drv   <= 1'b0;
      ext_rd_n  <= 1'b1;
      ext_wr_n  <= 1'b1;
      din       <= 8'h00;
      din_valid <= 1'b0;
      busy      <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      ext_addr  <= ext_addr_nx_s;
      ext_dout  <= ext_dout_nx_s;
      ext_drv   <= ext_drv_nx_s;
      ext_rd_n  <= ext_rd_n_nx_s;
      ext_wr_n  <= ext_wr_n_nx_s;
      din       <= din_nx_s;
      din_valid <= din_valid_nx_s;
      busy      <= busy_nx_s;
      proto_err <= proto_err_nx_s;
    end
  end

`ifdef SM83_BUS_STATS_EN
  // Saturating counts of started read and write cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_count <= 16'h0000;
      wr_count <= 16'h0000;
    end else begin
      if (rd_start_s && (rd_count != 16'hFFFF)) begin
        rd_count <= rd_count + 16'h0001;
      end
      if (wr_start_s && (wr_count != 16'hFFFF)) begin
        wr_count <= wr_count + 16'h0001;
      end
    end
  end
`endif

endmodule

// File: doc/sm83_bus_if.md
SM83_BUS_IF -- requirements
Module: sm83_bus_if

Interface
REQ-001 The block SHALL have parameters: none; all widths fixed (address 16 bit, data 8 bit).
REQ-002 The block SHALL have these ports:
  clk  in  1  system clock, all state on rising edge
  reset  in  1  asynchronous, active-high reset
  t1, t2, t3, t4  in  1 each  one-hot T-state strobes from the sequencer; exactly one is high per clk
  req_rd  in  1  core requests a read in the next M-cycle; sampled on the t4 edge
  req_wr  in  1  core requests a write in the next M-cycle; sampled on the t4 edge
  req_addr  in  16  request address, sampled on the t4 edge
  req_dout  in  8  write data, sampled on the t4 edge
  ext_din  in  8  external data bus input
  ext_addr  out  16  external address bus
  ext_dout  out  8  external write data
  ext_drv  out  1  data bus output enable
  ext_rd_n  out  1  read strobe, active low
  ext_wr_n  out  1  write strobe, active low
  din  out  8  latched read data to core
  din_valid  out  1  one-clock pulse, din updated
  busy  out  1  bus cycle in progress
  proto_err  out  1  sticky protocol-error flag

Function
REQ-003 The block SHALL implement states IDLE, RD, WR; every output SHALL be a register output.
REQ-004 The "t4 edge" is the rising clk edge with t4 high; the bus cycle occupies the following t1..t4.
REQ-005 On the t4 edge: req_rd -> RD; else req_wr -> WR; else IDLE. Any state can reach any state.
REQ-006 On entering RD or WR: ext_addr <= req_addr; busy <= 1.
REQ-007 On entering WR: ext_dout <= req_dout.
REQ-008 In IDLE, ext_addr and ext_dout SHALL hold their last values and busy SHALL be 0.
REQ-009 RD: ext_rd_n SHALL be 0 from the t4 edge to the t3 edge, i.e. low during t1, t2 and t3, and high during t4.
REQ-010 RD: on the t3 edge, din <= ext_din and din_valid <= 1. din_valid SHALL be high only during t4.
REQ-011 WR: ext_drv SHALL be 1 from the t4 edge entering WR to the next t4 edge, i.e. during t1..t4.
REQ-012 WR: ext_wr_n SHALL be 0 from the t1 edge to the t3 edge, i.e. low during t2 and t3.
REQ-013 ext_rd_n and ext_wr_n SHALL never be 0 in the same clk; ext_drv SHALL be 0 whenever ext_rd_n is 0.
REQ-014 Back-to-back cycles: a request on the t4 edge that ends a cycle starts the next cycle with no idle M-cycle. busy SHALL stay 1.
REQ-015 req_rd and req_wr both high on a t4 edge: the read SHALL win and proto_err SHALL be set to 1.
REQ-016 req_rd or req_wr high on a non-t4 edge SHALL be ignored and SHALL not set proto_err.
REQ-017 T-strobes that are not one-hot (zero or several high) SHALL set proto_err; the state SHALL be held.
REQ-018 proto_err SHALL clear only on reset.

Reset
REQ-019 Asserting reset SHALL immediately (asynchronously) set: state IDLE; ext_rd_n = 1; ext_wr_n = 1; ext_drv = 0; busy = 0; din_valid = 0; proto_err = 0; ext_addr = 0; ext_dout = 0; din = 0.
REQ-020 Reset during an active cycle SHALL abort it with no din_valid. The first cycle after release SHALL start only on a t4 edge.

Configuration
REQ-021 Macro SM83_BUS_STATS_EN SHALL control a set of statistics counters.
  - Defined: add outputs rd_count[15:0] and wr_count[15:0], reset to 0. Each increments on entry to RD or WR respectively and saturates at 16'hFFFF.
  - Undefined: these ports and counters SHALL NOT exist; all other behaviour is identical.

Verification
REQ-022 Read: req_rd=1, req_addr=16'hC123 at a t4 edge, ext_din=8'h5A -> ext_addr=16'hC123 and ext_rd_n=0 during t1..t3; din=8'h5A with din_valid=1 only during t4.
REQ-023 Write: req_wr=1, req_addr=16'hFF40, req_dout=8'h91 -> ext_dout=8'h91 and ext_drv=1 during t1..t4; ext_wr_n=0 during t2..t3 only; din_valid stays 0.
REQ-024 Back-to-back: read 16'h0100, then write 16'h0101 (8'h3C), then idle -> busy=1 for 8 clks then 0; ext_rd_n and ext_wr_n are never low together.
REQ-025 Conflict: req_rd=req_wr=1 at a t4 edge -> read cycle executes and proto_err=1 until reset. Request high only at t2 -> no cycle and proto_err=0.
REQ-026 Reset at t2 of a read -> ext_rd_n=1 in the same clk with no clock edge needed; din_valid never pulses; with SM83_BUS_STATS_EN defined, rd_count=0.
